// File: rtl/thmitll_emu_pkg.sv
// rtl/thmitll_emu_pkg.sv - shared types, limits and pulse-detect helper for the SFQ gate emulator
package thmitll_emu_pkg;

    typedef enum logic {
        GATE_AND = 1'b0,
        GATE_OR  = 1'b1
    } gate_mode_e;

    localparam int MAX_N_IN  = 16;
    localparam int MAX_DELAY = 15;
    localparam int MAX_HOLD  = 7;

    // A level change between two consecutive samples is one pulse; nothing counts until armed.
    function automatic logic [MAX_N_IN-1:0] pulse_detect(
        input logic [MAX_N_IN-1:0] cur,
        input logic [MAX_N_IN-1:0] prev,
        input logic                armed
    );
        return armed ? (cur ^ prev) : '0;
    endfunction

endpackage

// File: rtl/thmitll_pulse_det.sv
// rtl/thmitll_pulse_det.sv - toggle-to-pulse detector with a resync cycle after reset
module thmitll_pulse_det
    import thmitll_emu_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tog_i,
    output logic [WIDTH-1:0] pulse_o
);

    logic [WIDTH-1:0] in_q;
    logic             armed_q;

    // The first edge out of reset only captures the line levels, so stale highs never look like pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q    <= '0;
            armed_q <= 1'b0;
        end else begin
            in_q    <= tog_i;
            armed_q <= 1'b1;
        end
    end

    assign pulse_o = WIDTH'(pulse_detect(MAX_N_IN'(tog_i), MAX_N_IN'(in_q), armed_q));

endmodule

// File: rtl/thmitll_andn_pulse_emu.sv
// rtl/thmitll_andn_pulse_emu.sv - clocked RSFQ N-input gate emulation; THMITLL_HOLD_CHECK_EN adds the hold checker
module thmitll_andn_pulse_emu
    import thmitll_emu_pkg::*;
#(
    parameter int N_IN     = 2,
    parameter int MODE     = 0,
    parameter int DELAY    = 5,
    parameter int HOLD_CYC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] a,
    input  logic            clk_sfq,
    output logic            q,
    output logic            hold_viol,
    output logic [N_IN-1:0] viol_mask
);

    localparam gate_mode_e GATE_MODE = (MODE == 1) ? GATE_OR : GATE_AND;
    localparam int         PIPE_LEN  = (DELAY > MAX_DELAY) ? MAX_DELAY : ((DELAY < 1) ? 1 : DELAY);

    logic [N_IN-1:0]     a_pulse;
    logic                sfq_pulse;
    logic [N_IN-1:0]     flag_q, flag_d;
    logic [PIPE_LEN-1:0] pipe_q, pipe_d;
    logic                q_q, q_d;
    logic                fire;

    thmitll_pulse_det #(.WIDTH(N_IN)) u_det_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .tog_i   (a),
        .pulse_o (a_pulse)
    );

    thmitll_pulse_det #(.WIDTH(1)) u_det_sfq (
        .clk     (clk),
        .rst_n   (rst_n),
        .tog_i   (clk_sfq),
        .pulse_o (sfq_pulse)
    );

    // Arrivals coincident with an evaluation belong to the next period, hence clear-then-set.
    always_comb begin
        fire   = sfq_pulse && ((GATE_MODE == GATE_OR) ? (|flag_q) : (&flag_q));
        flag_d = (sfq_pulse ? '0 : flag_q) | a_pulse;
        pipe_d = '0;
        pipe_d[0] = fire;
        for (int i = 1; i < PIPE_LEN; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        q_d = q_q ^ pipe_q[PIPE_LEN-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= '0;
            pipe_q <= '0;
            q_q    <= 1'b0;
        end else begin
            flag_q <= flag_d;
            pipe_q <= pipe_d;
            q_q    <= q_d;
        end
    end

    assign q = q_q;

`ifdef THMITLL_HOLD_CHECK_EN
    localparam int         HOLD_LEN  = (HOLD_CYC > MAX_HOLD) ? MAX_HOLD : HOLD_CYC;
    localparam int         WIN_W     = $clog2(MAX_HOLD + 1);
    localparam logic [WIN_W-1:0] WIN_RELOAD = (HOLD_LEN > 0) ? WIN_W'(HOLD_LEN - 1) : '0;

    logic [WIN_W-1:0] win_q, win_d;
    logic             in_win;
    logic [N_IN-1:0]  hit;
    logic [N_IN-1:0]  mask_q, mask_d;
    logic             viol_q, viol_d;

    // win_q counts the window cycles still open after the evaluation cycle itself.
    always_comb begin
        in_win = (HOLD_LEN != 0) && (sfq_pulse || (win_q != '0));
        win_d  = win_q;
        if (sfq_pulse) begin
            win_d = WIN_RELOAD;
        end else if (win_q != '0) begin
            win_d = win_q - 1'b1;
        end
        hit    = a_pulse & {N_IN{in_win}};
        mask_d = mask_q | hit;
        viol_d = viol_q | (|hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q  <= '0;
            mask_q <= '0;
            viol_q <= 1'b0;
        end else begin
            win_q  <= win_d;
            mask_q <= mask_d;
            viol_q <= viol_d;
        end
    end

    assign hold_viol = viol_q;
    assign viol_mask = mask_q;
`else
    // Hold window length has no effect when the checker is compiled out.
    localparam int unused_hold_cyc = (HOLD_CYC > MAX_HOLD) ? MAX_HOLD : HOLD_CYC;

    assign hold_viol = 1'b0;
    assign viol_mask = '0;
`endif

endmodule

// File: tb/tb_thmitll_andn_pulse_emu.sv
// tb/tb_thmitll_andn_pulse_emu.sv - scoreboard bench for AND (N=3, DELAY=5) and OR (N=2, DELAY=1) gates
module tb_thmitll_andn_pulse_emu;

`ifdef THMITLL_HOLD_CHECK_EN
    localparam int HOLD_EXP = 1;
`else
    localparam int HOLD_EXP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] a_and = '0;
    logic       sfq_and = 1'b0;
    logic       q_and, hv_and;
    logic [2:0] vm_and;
    logic [1:0] a_or = '0;
    logic       sfq_or = 1'b0;
    logic       q_or, hv_or;
    logic [1:0] vm_or;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int sb_and[$];
    int sb_or[$];
    logic [2:0] fl_and = '0;
    logic [1:0] fl_or = '0;

    thmitll_andn_pulse_emu #(.N_IN(3), .MODE(0), .DELAY(5), .HOLD_CYC(2)) dut_and (
        .clk(clk), .rst_n(rst_n), .a(a_and), .clk_sfq(sfq_and),
        .q(q_and), .hold_viol(hv_and), .viol_mask(vm_and)
    );

    thmitll_andn_pulse_emu #(.N_IN(2), .MODE(1), .DELAY(1), .HOLD_CYC(0)) dut_or (
        .clk(clk), .rst_n(rst_n), .a(a_or), .clk_sfq(sfq_or),
        .q(q_or), .hold_viol(hv_or), .viol_mask(vm_or)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Stimulus is detected at the next edge (cyc+1); a fire toggles q DELAY edges later.
    task automatic drv_and(input logic [2:0] m, input logic s);
        a_and   = a_and ^ m;
        sfq_and = sfq_and ^ s;
        if (s) begin
            if (&fl_and) sb_and.push_back(cyc + 1 + 5);
            fl_and = m;
        end else begin
            fl_and = fl_and | m;
        end
        step();
    endtask

    task automatic drv_or(input logic [1:0] m, input logic s);
        a_or   = a_or ^ m;
        sfq_or = sfq_or ^ s;
        if (s) begin
            if (|fl_or) sb_or.push_back(cyc + 1 + 1);
            fl_or = m;
        end else begin
            fl_or = fl_or | m;
        end
        step();
    endtask

    task automatic do_reset(input bit ones);
        rst_n = 1'b0;
        sb_and.delete();
        sb_or.delete();
        fl_and = '0;
        fl_or  = '0;
        if (ones) begin
            a_and = '1;
            a_or  = '1;
        end
        #1;
        chk("rst_q_and", int'(q_and), 0);
        chk("rst_hv_and", int'(hv_and), 0);
        chk("rst_vm_and", int'(vm_and), 0);
        chk("rst_q_or", int'(q_or), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
    endtask

    initial begin : monitor
        logic prev_and, prev_or;
        prev_and = 1'b0;
        prev_or  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_and = q_and;
                prev_or  = q_or;
            end else begin
                if (q_and != prev_and) begin
                    if (sb_and.size() > 0) chk("q_and_toggle_cyc", cyc, sb_and.pop_front());
                    else chk("q_and_spurious", int'(q_and), int'(prev_and));
                    prev_and = q_and;
                end else if (sb_and.size() > 0 && sb_and[0] <= cyc) begin
                    void'(sb_and.pop_front());
                    chk("q_and_missing", int'(q_and), int'(!prev_and));
                end
                if (q_or != prev_or) begin
                    if (sb_or.size() > 0) chk("q_or_toggle_cyc", cyc, sb_or.pop_front());
                    else chk("q_or_spurious", int'(q_or), int'(prev_or));
                    prev_or = q_or;
                end else if (sb_or.size() > 0 && sb_or[0] <= cyc) begin
                    void'(sb_or.pop_front());
                    chk("q_or_missing", int'(q_or), int'(!prev_or));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        #2;
        do_reset(1'b0);

        // AND: three staggered arrivals then an evaluation; then an empty evaluation.
        drv_and(3'b001, 1'b0);
        drv_and(3'b010, 1'b0);
        drv_and(3'b100, 1'b0);
        idle(3);
        drv_and(3'b000, 1'b1);
        idle(11);
        drv_and(3'b000, 1'b1);
        idle(7);
        chk("q_and_level_after_empty_eval", int'(q_and), 1);

        // Reset with a toggle in flight and inputs forced high across release.
        drv_and(3'b111, 1'b0);
        drv_and(3'b000, 1'b1);
        idle(2);
        do_reset(1'b1);
        drv_and(3'b000, 1'b1);
        drv_or(2'b00, 1'b1);
        idle(8);

        // AND: partial arrivals must not fire and must not leak into the next period.
        drv_and(3'b101, 1'b0);
        drv_and(3'b000, 1'b1);
        drv_and(3'b010, 1'b0);
        drv_and(3'b000, 1'b1);
        idle(7);

        // AND: arrival coincident with evaluation counts toward the next period.
        drv_and(3'b001, 1'b1);
        drv_and(3'b110, 1'b0);
        drv_and(3'b000, 1'b1);
        idle(7);

        // OR: single arrival, coincident arrival, back-to-back evaluations.
        drv_or(2'b10, 1'b0);
        drv_or(2'b00, 1'b1);
        idle(3);
        drv_or(2'b01, 1'b1);
        drv_or(2'b00, 1'b1);
        idle(3);
        drv_or(2'b11, 1'b0);
        drv_or(2'b11, 1'b1);
        drv_or(2'b00, 1'b1);
        idle(4);
        drv_or(2'b00, 1'b1);
        drv_or(2'b10, 1'b0);
        chk("hv_or_hold_zero_disabled", int'(hv_or), 0);
        idle(3);

        // Hold window of two cycles on the AND gate.
        do_reset(1'b0);
        drv_and(3'b000, 1'b1);
        drv_and(3'b000, 1'b0);
        drv_and(3'b001, 1'b0);
        chk("hv_and_outside_window", int'(hv_and), 0);
        chk("vm_and_outside_window", int'(vm_and), 0);
        drv_and(3'b000, 1'b1);
        chk("hv_and_at_eval", int'(hv_and), 0);
        drv_and(3'b010, 1'b0);
        chk("hv_and_inside_window", int'(hv_and), HOLD_EXP);
        chk("vm_and_inside_window", int'(vm_and), HOLD_EXP * 2);
        idle(3);
        chk("hv_and_sticky", int'(hv_and), HOLD_EXP);
        idle(6);
        do_reset(1'b0);

        idle(10);
        chk("sb_and_drained", sb_and.size(), 0);
        chk("sb_or_drained", sb_or.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/thmitll_andn_pulse_emu.md
# thmitll_andn_pulse_emu

Cycle-based emulation of a clocked RSFQ N-input gate, used in FPGA/RTL co-simulation of SFQ netlists. Every edge (rising or falling) on an input line is one SFQ pulse. Each data input sets an arrival flag. A pulse on `clk_sfq` evaluates the flags, toggles `q` after a programmable delay if the gate condition holds, and clears the flags. A hold-window checker flags data pulses that arrive too soon after an evaluation pulse.

## Interface
- `N_IN`, 2: number of data inputs, 2..16.
- `MODE`, 0: gate condition. 0 = AND (all flags set), 1 = OR (any flag set).
- `DELAY`, 5: cycles from evaluation to the `q` toggle, 1..15.
- `HOLD_CYC`, 1: length of the hold window in cycles, 0..7. 0 disables checking.
- `clk` input 1: emulation clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `a` input N_IN: toggle-encoded data pulses. Each level change is one pulse.
- `clk_sfq` input 1: toggle-encoded SFQ clock pulse.
- `q` output 1: toggle-encoded output. Each level change is one output pulse.
- `hold_viol` output 1: sticky violation flag. Cleared only by reset.
- `viol_mask` output N_IN: sticky per-input violation bits.

## Operation
- Pulse detection: each input is registered. A pulse is detected in cycle t when the value sampled at edge t differs from the stored value at edge t-1.
- Resync after reset:
  - The first edge after `rst_n` deasserts only loads the input registers. No pulses are detected in that cycle.
  - Levels already high at reset release are therefore never counted as pulses.
- Arrival flags, `flag[N_IN-1:0]`:
  - A pulse on `a[i]` sets `flag[i]`.
  - Repeat pulses on the same input within one period are idempotent.
- Evaluation: a pulse on `clk_sfq` detected at t evaluates the flags as they stood before t.
  - AND mode: fire when every flag is set.
  - OR mode: fire when any flag is set.
  - All flags clear at edge t.
- Simultaneous events: an `a[i]` pulse detected in the same cycle as a `clk_sfq` pulse belongs to the next period. `flag[i]` is set after the clear.
- Fire: one toggle command enters a DELAY-deep shift pipeline. `q` inverts when the command exits.
  - Back-to-back evaluations in consecutive cycles each produce their own toggle.
  - The pipeline never merges or drops commands.
- Hold window: cycles t .. t+HOLD_CYC-1 after an evaluation detected at t.
  - An `a[i]` pulse detected inside the window sets `viol_mask[i]` and `hold_viol`.
  - The pulse is still recorded as an arrival.
  - A new evaluation inside an open window restarts the window.
- Reset (asynchronous, also mid-operation):
  - `q` = 0, `hold_viol` = 0, `viol_mask` = 0.
  - Flags, pipeline, window counter and input registers cleared.
  - Resync cycle armed.

## Timing
- An arrival flag is visible one cycle after the pulse is detected.
- `q` toggles at edge t+DELAY for an evaluation detected at t.
- `hold_viol` and `viol_mask` are registered. They assert at the edge that detects the offending pulse.
- No combinational paths from inputs to outputs.

## Configuration
- `THMITLL_HOLD_CHECK_EN` defined: hold-window counter and violation logic are present, as described above.
- Not defined:
  - `hold_viol` and `viol_mask` are tied to 0.
  - `HOLD_CYC` is ignored.
  - No window counter is synthesized.
  - Arrival and evaluation behaviour are unchanged.

## Structure
- Package `thmitll_emu_pkg` holds:
  - the gate-mode enumeration (`GATE_AND`, `GATE_OR`);
  - the limits `MAX_N_IN` = 16, `MAX_DELAY` = 15, `MAX_HOLD` = 7;
  - a pulse-detect function.
- Sub-module `thmitll_pulse_det`: parametrised-width toggle-to-pulse detector with the resync-after-reset behaviour. It is instantiated once for `a` (width N_IN) and once for `clk_sfq` (width 1).
- The top level holds the flags, evaluation logic, delay pipeline, hold checker and output register.

## Test plan
- AND, N_IN=3, DELAY=5:
  - Toggle `a[0]`, `a[1]`, `a[2]` at cycles 2, 3, 4, then `clk_sfq` at 8 -> `q` 0->1 at 13.
  - A second `clk_sfq` at 20 with no arrivals -> `q` stays 1.
- AND, N_IN=3, only `a[0]` and `a[2]` pulse before `clk_sfq` -> no `q` toggle; flags cleared.
- OR mode: a single `a[1]` pulse, then `clk_sfq` -> `q` toggles.
- Same-cycle `a[0]`/`clk_sfq` pulse, then `a[1]` and `clk_sfq`, with N_IN=2, AND -> first evaluation does not fire, second fires.
- Hold check with `THMITLL_HOLD_CHECK_EN`, HOLD_CYC=2: `clk_sfq` at 10, `a[1]` at 11 -> `hold_viol`=1 and `viol_mask`=2'b10 at 11.
  - Without the macro, the same stimulus leaves both outputs at 0.
- Reset:
  - Hold `a`=all-ones while `rst_n` is low; release -> no pulse is detected.
  - Assert `rst_n` with a toggle pending in the pipeline -> `q` = 0 immediately and the pending toggle never appears.
